ram_writer: RTL and testbench

- Upstream companion to the DDR3 read path. Accepts a stream of 16-bit words, each with its own 27-bit word address, for example from the SD-card loader.
- Packs words into 8-word (128-bit) bursts and writes each burst to the MIG user interface as two 64-bit write-data beats plus one write command.
- Burst and beat layout matches the read path exactly:
  - first beat carries words 4-7 (burst[127:64]);
  - end beat carries words 0-3 (burst[63:0]);
  - word w occupies burst[w*16 +: 16].

---
 rtl/ram_writer_if.sv | 34 +++
 rtl/ram_writer.sv | 159 +++++++++++++++
 tb/tb_ram_writer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/ram_writer_if.sv
// Stream-in / MIG-out signal bundle for ram_writer. The slave modport is the
// writer's view; master is the view of the surrounding logic (source + MIG).
interface ram_writer_if #(
    parameter int ADDR_W = 27,
    parameter int DATA_W = 64
);
    logic [15:0]         in_data;
    logic [ADDR_W-1:0]   in_address;
    logic                in_valid;
    logic                in_ready;
    logic                flush;
    logic                busy;
    logic [ADDR_W-1:0]   ram_address;
    logic [2:0]          ram_cmd;
    logic                ram_en;
    logic                ram_rdy;
    logic [DATA_W-1:0]   ram_wdf_data;
    logic [DATA_W/8-1:0] ram_wdf_mask;
    logic                ram_wdf_wren;
    logic                ram_wdf_end;
    logic                ram_wdf_rdy;

    modport slave (
        input  in_data, in_address, in_valid, flush, ram_rdy, ram_wdf_rdy,
        output in_ready, busy, ram_address, ram_cmd, ram_en,
               ram_wdf_data, ram_wdf_mask, ram_wdf_wren, ram_wdf_end
    );

    modport master (
        output in_data, in_address, in_valid, flush, ram_rdy, ram_wdf_rdy,
        input  in_ready, busy, ram_address, ram_cmd, ram_en,
               ram_wdf_data, ram_wdf_mask, ram_wdf_wren, ram_wdf_end
    );
endinterface

// File: rtl/ram_writer.sv
// Packs 16-bit addressed words into 8-word bursts and writes them to the MIG UI
// as two 64-bit beats (words 4-7 first) plus one write command.
// Optional macro RAM_WRITER_MASK_EN: drive byte masks from the slot-valid bits.
module ram_writer #(
    parameter int ADDR_W = 27,
    parameter int DATA_W = 64
) (
    input logic        clk,
    input logic        reset,
    ram_writer_if.slave bus
);
    typedef enum logic [1:0] {FILL, BEAT0, BEAT1, CMD} state_e;

    state_e                state_q, state_d;
    logic [2*DATA_W-1:0]   buffer_q, buffer_d;
    logic [7:0]            valid_q, valid_d;
    logic [ADDR_W-4:0]     burst_addr_q, burst_addr_d;

    logic [ADDR_W-1:0]     ram_address_q, ram_address_d;
    logic [2:0]            ram_cmd_q, ram_cmd_d;
    logic                  ram_en_q, ram_en_d;
    logic [DATA_W-1:0]     ram_wdf_data_q, ram_wdf_data_d;
    logic [DATA_W/8-1:0]   ram_wdf_mask_q, ram_wdf_mask_d;
    logic                  ram_wdf_wren_q, ram_wdf_wren_d;
    logic                  ram_wdf_end_q, ram_wdf_end_d;

    logic [ADDR_W-4:0]     in_burst;
    logic [2:0]            in_slot;
    logic                  nonempty;
    logic                  mismatch;
    logic                  in_ready;
    logic                  accept;

    assign in_burst = bus.in_address[ADDR_W-1:3];
    assign in_slot  = bus.in_address[2:0];

`ifdef RAM_WRITER_MASK_EN
    function automatic logic [7:0] slot_mask(input logic [3:0] v);
        logic [7:0] m;
        m = '0;
        for (int unsigned k = 0; k < 4; k++) m[2*k +: 2] = {2{~v[k]}};
        return m;
    endfunction
`endif

    // A word for a different burst is held off so the current burst drains first.
    always_comb begin
        nonempty = |valid_q;
        mismatch = bus.in_valid && nonempty && (in_burst != burst_addr_q);
        in_ready = !reset && (state_q == FILL) && !(bus.flush && nonempty) && !mismatch;
        accept   = bus.in_valid && in_ready;
    end

    always_comb begin
        buffer_d     = buffer_q;
        valid_d      = valid_q;
        burst_addr_d = burst_addr_q;
        if (accept) begin
            buffer_d[{in_slot, 4'b0000} +: 16] = bus.in_data;
            valid_d[in_slot] = 1'b1;
            if (!nonempty) burst_addr_d = in_burst;
        end
        if (state_q == CMD && bus.ram_rdy) begin
            buffer_d = '0;
            valid_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FILL;
            buffer_q     <= '0;
            valid_q      <= '0;
            burst_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            buffer_q     <= buffer_d;
            valid_q      <= valid_d;
            burst_addr_q <= burst_addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FILL: begin
                if (accept && (&valid_d))                    state_d = BEAT0;
                else if (nonempty && (bus.flush || mismatch)) state_d = BEAT0;
            end
            BEAT0: if (bus.ram_wdf_rdy) state_d = BEAT1;
            BEAT1: if (bus.ram_wdf_rdy) state_d = CMD;
            CMD:   if (bus.ram_rdy)     state_d = FILL;
            default:                    state_d = FILL;
        endcase
    end

    // Outputs are decoded from the next state so the registers line up with it.
    always_comb begin
        ram_address_d  = '0;
        ram_cmd_d      = 3'b000;
        ram_en_d       = 1'b0;
        ram_wdf_data_d = '0;
        ram_wdf_mask_d = '0;
        ram_wdf_wren_d = 1'b0;
        ram_wdf_end_d  = 1'b0;
        unique case (state_d)
            BEAT0: begin
                ram_wdf_wren_d = 1'b1;
                ram_wdf_data_d = buffer_d[2*DATA_W-1:DATA_W];
`ifdef RAM_WRITER_MASK_EN
                ram_wdf_mask_d = slot_mask(valid_d[7:4]);
`endif
            end
            BEAT1: begin
                ram_wdf_wren_d = 1'b1;
                ram_wdf_end_d  = 1'b1;
                ram_wdf_data_d = buffer_d[DATA_W-1:0];
`ifdef RAM_WRITER_MASK_EN
                ram_wdf_mask_d = slot_mask(valid_d[3:0]);
`endif
            end
            CMD: begin
                ram_en_d      = 1'b1;
                ram_address_d = {burst_addr_d, 3'b000};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ram_address_q  <= '0;
            ram_cmd_q      <= '0;
            ram_en_q       <= 1'b0;
            ram_wdf_data_q <= '0;
            ram_wdf_mask_q <= '0;
            ram_wdf_wren_q <= 1'b0;
            ram_wdf_end_q  <= 1'b0;
        end else begin
            ram_address_q  <= ram_address_d;
            ram_cmd_q      <= ram_cmd_d;
            ram_en_q       <= ram_en_d;
            ram_wdf_data_q <= ram_wdf_data_d;
            ram_wdf_mask_q <= ram_wdf_mask_d;
            ram_wdf_wren_q <= ram_wdf_wren_d;
            ram_wdf_end_q  <= ram_wdf_end_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.busy         = (state_q != FILL) || nonempty;
    assign bus.ram_address  = ram_address_q;
    assign bus.ram_cmd      = ram_cmd_q;
    assign bus.ram_en       = ram_en_q;
    assign bus.ram_wdf_data = ram_wdf_data_q;
    assign bus.ram_wdf_mask = ram_wdf_mask_q;
    assign bus.ram_wdf_wren = ram_wdf_wren_q;
    assign bus.ram_wdf_end  = ram_wdf_end_q;
endmodule

// File: tb/tb_ram_writer.sv
// Directed bench for ram_writer: records MIG beats/commands and compares them
// with hand-computed bursts.
module tb_ram_writer;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

`ifdef RAM_WRITER_MASK_EN
    localparam bit MASK_EN = 1'b1;
`else
    localparam bit MASK_EN = 1'b0;
`endif

    ram_writer_if bus ();
    ram_writer dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // {end, mask, data} per accepted beat; {cmd, address} per accepted command
    logic [72:0] beats[$];
    logic [29:0] cmds[$];

    always @(posedge clk) begin
        if (!reset) begin
            if (bus.ram_wdf_wren && bus.ram_wdf_rdy)
                beats.push_back({bus.ram_wdf_end, bus.ram_wdf_mask, bus.ram_wdf_data});
            if (bus.ram_en && bus.ram_rdy)
                cmds.push_back({bus.ram_cmd, bus.ram_address});
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_mask(input logic [7:0] m);
        return MASK_EN ? m : 8'h00;
    endfunction

    task automatic cycle();
        @(posedge clk); #1;
    endtask

    task automatic send_word(input logic [15:0] d, input logic [26:0] a);
        int unsigned n = 0;
        bus.in_data = d; bus.in_address = a; bus.in_valid = 1'b1;
        #1;
        while (!bus.in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) check("send_timeout", {63'd0, bus.in_ready}, 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        bus.flush = 1'b1;
        cycle();
        bus.flush = 1'b0;
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        while (bus.busy && n < 100) begin
            cycle();
            n++;
        end
        if (bus.busy) check("idle_timeout", {63'd0, bus.busy}, 64'd0);
    endtask

    task automatic check_burst(input string tag, input logic [63:0] hi, input logic [63:0] lo,
                               input logic [7:0] mhi, input logic [7:0] mlo, input logic [26:0] addr);
        logic [72:0] b0, b1;
        logic [29:0] c;
        check({tag, "_nbeats"}, 64'(beats.size()), 64'd2);
        check({tag, "_ncmds"}, 64'(cmds.size()), 64'd1);
        if (beats.size() == 2) begin
            b0 = beats[0]; b1 = beats[1];
            check({tag, "_b0_data"}, b0[63:0], hi);
            check({tag, "_b0_end"}, {63'd0, b0[72]}, 64'd0);
            check({tag, "_b0_mask"}, {56'd0, b0[71:64]}, {56'd0, exp_mask(mhi)});
            check({tag, "_b1_data"}, b1[63:0], lo);
            check({tag, "_b1_end"}, {63'd0, b1[72]}, 64'd1);
            check({tag, "_b1_mask"}, {56'd0, b1[71:64]}, {56'd0, exp_mask(mlo)});
        end
        if (cmds.size() == 1) begin
            c = cmds[0];
            check({tag, "_cmd"}, {61'd0, c[29:27]}, 64'd0);
            check({tag, "_addr"}, {37'd0, c[26:0]}, {37'd0, addr});
        end
        beats.delete();
        cmds.delete();
    endtask

    initial begin
        reset = 1'b1;
        bus.in_data = '0; bus.in_address = '0; bus.in_valid = 1'b0; bus.flush = 1'b0;
        bus.ram_rdy = 1'b1; bus.ram_wdf_rdy = 1'b1;
        cycle(); cycle();
        check("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
        cycle();
        reset = 1'b0;
        cycle();
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_wren", {63'd0, bus.ram_wdf_wren}, 64'd0);
        check("rst_end", {63'd0, bus.ram_wdf_end}, 64'd0);
        check("rst_en", {63'd0, bus.ram_en}, 64'd0);
        check("rst_cmd", {61'd0, bus.ram_cmd}, 64'd0);
        check("rst_addr", {37'd0, bus.ram_address}, 64'd0);
        check("rst_data", bus.ram_wdf_data, 64'd0);
        check("rst_mask", {56'd0, bus.ram_wdf_mask}, 64'd0);
        check("rst_in_ready_after", {63'd0, bus.in_ready}, 64'd1);

        // Full burst
        for (int i = 0; i < 8; i++) send_word(16'h1110 + 16'(i), 27'h40 + 27'(i));
        check("full_beat0_wren", {63'd0, bus.ram_wdf_wren}, 64'd1);
        check("full_beat0_end", {63'd0, bus.ram_wdf_end}, 64'd0);
        wait_idle();
        check_burst("full", 64'h1117111611151114, 64'h1113111211111110, 8'h00, 8'h00, 27'h40);

        // Address mismatch evicts the partial burst
        send_word(16'hAAAA, 27'h0A);
        bus.in_data = 16'hBBBB; bus.in_address = 27'h13; bus.in_valid = 1'b1;
        #1;
        check("mis_in_ready", {63'd0, bus.in_ready}, 64'd0);
        send_word(16'hBBBB, 27'h13);
        check_burst("mis", 64'h0, 64'h0000AAAA00000000, 8'hFF, 8'hCF, 27'h08);
        check("mis_busy", {63'd0, bus.busy}, 64'd1);
        pulse_flush();
        wait_idle();
        check_burst("mis2", 64'h0, 64'hBBBB000000000000, 8'hFF, 8'h3F, 27'h10);

        // Back-pressure on write data, then on the command
        bus.ram_wdf_rdy = 1'b0;
        for (int i = 0; i < 8; i++) send_word(16'h2000 + 16'(i), 27'h200 + 27'(i));
        for (int i = 0; i < 5; i++) begin
            check("wdf_hold_wren", {63'd0, bus.ram_wdf_wren}, 64'd1);
            check("wdf_hold_end", {63'd0, bus.ram_wdf_end}, 64'd0);
            check("wdf_hold_data", bus.ram_wdf_data, 64'h2007200620052004);
            check("wdf_hold_in_ready", {63'd0, bus.in_ready}, 64'd0);
            cycle();
        end
        bus.ram_wdf_rdy = 1'b1;
        bus.ram_rdy = 1'b0;
        cycle();
        check("wdf_beat1_end", {63'd0, bus.ram_wdf_end}, 64'd1);
        check("wdf_beat1_data", bus.ram_wdf_data, 64'h2003200220012000);
        cycle();
        for (int i = 0; i < 4; i++) begin
            check("cmd_hold_en", {63'd0, bus.ram_en}, 64'd1);
            check("cmd_hold_cmd", {61'd0, bus.ram_cmd}, 64'd0);
            check("cmd_hold_addr", {37'd0, bus.ram_address}, 64'h200);
            check("cmd_hold_wren", {63'd0, bus.ram_wdf_wren}, 64'd0);
            cycle();
        end
        bus.ram_rdy = 1'b1;
        cycle();
        check("cmd_release_en", {63'd0, bus.ram_en}, 64'd0);
        wait_idle();
        check_burst("stall", 64'h2007200620052004, 64'h2003200220012000, 8'h00, 8'h00, 27'h200);

        // Flush with an empty buffer does nothing
        pulse_flush();
        for (int i = 0; i < 5; i++) cycle();
        check("eflush_beats", 64'(beats.size()), 64'd0);
        check("eflush_cmds", 64'(cmds.size()), 64'd0);
        check("eflush_busy", {63'd0, bus.busy}, 64'd0);

        // Two words then flush
        send_word(16'h1234, 27'h100);
        send_word(16'h5678, 27'h101);
        pulse_flush();
        wait_idle();
        check_burst("two", 64'h0, 64'h0000000056781234, 8'hFF, 8'hF0, 27'h100);

        // Highest address is slot 7 of the last burst
        send_word(16'hCAFE, 27'h7FFFFFF);
        pulse_flush();
        wait_idle();
        check_burst("wrap", 64'hCAFE000000000000, 64'h0, 8'h3F, 8'hFF, 27'h7FFFFF8);

        // Overwriting a slot keeps the later word
        send_word(16'h1111, 27'h300);
        send_word(16'h2222, 27'h300);
        pulse_flush();
        wait_idle();
        check_burst("ovw", 64'h0, 64'h0000000000002222, 8'hFF, 8'hFC, 27'h300);

        // Reset during BEAT1
        for (int i = 0; i < 8; i++) send_word(16'h5000 + 16'(i), 27'h500 + 27'(i));
        cycle();
        check("rb1_end", {63'd0, bus.ram_wdf_end}, 64'd1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        #1;
        check("rb1_wren", {63'd0, bus.ram_wdf_wren}, 64'd0);
        check("rb1_en", {63'd0, bus.ram_en}, 64'd0);
        check("rb1_busy", {63'd0, bus.busy}, 64'd0);
        check("rb1_in_ready", {63'd0, bus.in_ready}, 64'd1);
        for (int i = 0; i < 3; i++) cycle();
        check("rb1_cmds", 64'(cmds.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
